// File: rtl/result_writer.sv
// rtl/result_writer.sv - buffers ALU row results and writes them to result SRAM at consecutive addresses
module result_writer #(
    parameter int DATA_W      = 20,
    parameter int ADDR_W      = 8,
    parameter int NUM_RESULTS = 64,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [DATA_W-1:0] sum_in,
    input  logic              sum_valid,
    input  logic              mem_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [ADDR_W:0]   count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   OCC_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   OCC_FULL = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W:0]  CNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0]  LAST_ACC = (ADDR_W + 1)'(NUM_RESULTS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    occ;
    logic [ADDR_W:0]   accepted;
    logic [ADDR_W-1:0] addr_ptr;

    logic fifo_empty;
    logic fifo_full;
    logic pop;
    logic push;
    logic drop;

    assign fifo_empty = (occ == '0);
    assign fifo_full  = (occ == OCC_FULL);

    // Write strobe and address/data are decoded straight from registers so they stay stable while stalled
    assign mem_we    = !fifo_empty && (state == S_RUN || state == S_DRAIN);
    assign mem_addr  = addr_ptr;
    assign mem_wdata = mem_we ? {{(32 - DATA_W){1'b0}}, fifo_mem[rd_ptr]} : 32'd0;

    // A pop in the same cycle frees a slot, so a full FIFO can still accept
    assign pop  = mem_we && mem_ready;
    assign push = (state == S_RUN) && sum_valid && (!fifo_full || pop);
    assign drop = (state == S_RUN) && sum_valid && fifo_full && !pop;

    // FIFO storage needs no reset; occupancy alone decides what is valid
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= sum_in;
        end
    end

    // Job sequencing, FIFO pointers, address pointer and status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ      <= '0;
            accepted <= '0;
            addr_ptr <= '0;
            count    <= '0;
            overflow <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_RUN;
                        busy     <= 1'b1;
                        addr_ptr <= base_addr;
                        count    <= '0;
                        accepted <= '0;
                        overflow <= 1'b0;
                        wr_ptr   <= '0;
                        rd_ptr   <= '0;
                        occ      <= '0;
                    end
                end
                S_RUN: begin
                    if (push && accepted == LAST_ACC) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (fifo_empty) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase

            if (push) begin
                wr_ptr   <= wr_ptr + PTR_ONE;
                accepted <= accepted + CNT_ONE;
            end
            if (pop) begin
                rd_ptr   <= rd_ptr + PTR_ONE;
                addr_ptr <= addr_ptr + ADDR_ONE;
                count    <= count + CNT_ONE;
            end
            if (push && !pop) begin
                occ <= occ + OCC_ONE;
            end else if (pop && !push) begin
                occ <= occ - OCC_ONE;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule
